ibex_rf_cache_lru_ctrl: RTL

Parametrised successor to the single-level register-file cache. A flop-based architectural register file serves as the backing store. In front of it sits an N-entry fully associative operand cache with true-LRU replacement, write-through/no-allocate writes and a deterministic miss-stall FSM. It sits in the ID stage between the decoder's operand addresses and the ALU operand muxes, and raises stall_o to the controller on an operand miss.

---
 rtl/ibex_rf_cache_lru_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ibex_rf_cache_lru_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rf_cache_lru_ctrl
// Purpose  : Operand cache in front of a flop-based architectural register
//            file. The cache is N-entry, fully associative, true-LRU. Writes
//            are write-through/no-allocate. A two-state FSM stalls ID while a
//            missing operand is filled from the backing store.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   raddr_a_i/rreq_a_i      read port A address / operand needed
//   rdata_a_o               read port A data (valid while stall_o=0)
//   raddr_b_i/rreq_b_i      read port B address / operand needed
//   rdata_b_o               read port B data (valid while stall_o=0)
//   waddr_a_i/wdata_a_i/we_a_i  write port
//   stall_o                 operand miss in progress; ID holds its inputs
//   hit_count_o             read hits   (RF_CACHE_PERF_EN, else 0)
//   miss_count_o            fills done  (RF_CACHE_PERF_EN, else 0)
// Options
//   `define RF_CACHE_PERF_EN adds saturating hit/miss counters.
// ============================================================================
module ibex_rf_cache_lru_ctrl #(
  parameter bit          RV32E       = 1'b0,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned NumEntries  = 4,
  parameter int unsigned FillLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [4:0]           raddr_a_i,
  input  logic                 rreq_a_i,
  output logic [DataWidth-1:0] rdata_a_o,
  input  logic [4:0]           raddr_b_i,
  input  logic                 rreq_b_i,
  output logic [DataWidth-1:0] rdata_b_o,
  input  logic [4:0]           waddr_a_i,
  input  logic [DataWidth-1:0] wdata_a_i,
  input  logic                 we_a_i,
  output logic                 stall_o,
  output logic [31:0]          hit_count_o,
  output logic [31:0]          miss_count_o
);

  localparam int unsigned AgeW = $clog2(NumEntries);
  localparam logic [1:0]  c_cnt_load = (FillLatency > 1) ? 2'(FillLatency - 2) : 2'd0;

  typedef logic [NumEntries-1:0][AgeW-1:0] age_vec_t;
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FILL = 1'b1} state_e;

  // Under RV32E bit 4 is dropped, so x16..x31 alias x0..x15.
  function automatic logic [4:0] eff_addr(input logic [4:0] a);
    return {(RV32E ? 1'b0 : a[4]), a[3:0]};
  endfunction

  // One LRU access to entry k: everything younger than k ages by one.
  function automatic age_vec_t touch(input age_vec_t a, input logic [AgeW-1:0] k);
    age_vec_t r;
    r = a;
    for (int j = 0; j < NumEntries; j++) begin
      if (a[j] < a[k]) r[j] = a[j] + AgeW'(1);
    end
    r[k] = '0;
    return r;
  endfunction

  // Backing store is always 32 deep; under RV32E the upper half is never
  // written and reduces to constant zero.
  logic [DataWidth-1:0]  r_rf    [32];
  logic [NumEntries-1:0] r_valid;
  logic [4:0]            r_tag   [NumEntries];
  logic [DataWidth-1:0]  r_data  [NumEntries];
  age_vec_t              r_age;
  state_e                r_state;
  logic [1:0]            r_cnt;

  logic [4:0]      w_ea_a, w_ea_b, w_ea_w, w_fill_addr;
  logic            w_hit_a, w_hit_b, w_hit_w;
  logic [AgeW-1:0] w_idx_a, w_idx_b, w_idx_w, w_vict;
  logic            w_miss_a, w_miss_b, w_we, w_fill_now, w_vict_found;
  state_e          w_state_next;
  logic [1:0]      w_cnt_next;
  age_vec_t        w_age_next;

  assign w_ea_a = eff_addr(raddr_a_i);
  assign w_ea_b = eff_addr(raddr_b_i);
  assign w_ea_w = eff_addr(waddr_a_i);

  // Tag compare on both read ports and the write port. x0 is never
  // allocated, but is excluded explicitly so it can never hit.
  always_comb begin
    w_hit_a = 1'b0; w_idx_a = '0;
    w_hit_b = 1'b0; w_idx_b = '0;
    w_hit_w = 1'b0; w_idx_w = '0;
    for (int i = 0; i < NumEntries; i++) begin
      if (r_valid[i] && r_tag[i] == w_ea_a && w_ea_a != 5'd0) begin
        w_hit_a = 1'b1; w_idx_a = AgeW'(i);
      end
      if (r_valid[i] && r_tag[i] == w_ea_b && w_ea_b != 5'd0) begin
        w_hit_b = 1'b1; w_idx_b = AgeW'(i);
      end
      if (r_valid[i] && r_tag[i] == w_ea_w && w_ea_w != 5'd0) begin
        w_hit_w = 1'b1; w_idx_w = AgeW'(i);
      end
    end
  end

  assign rdata_a_o   = w_hit_a ? r_data[w_idx_a] : '0;
  assign rdata_b_o   = w_hit_b ? r_data[w_idx_b] : '0;
  assign w_miss_a    = rreq_a_i && (w_ea_a != 5'd0) && !w_hit_a;
  assign w_miss_b    = rreq_b_i && (w_ea_b != 5'd0) && !w_hit_b;
  assign stall_o     = w_miss_a | w_miss_b;
  assign w_fill_addr = w_miss_a ? w_ea_a : w_ea_b;
  assign w_we        = we_a_i && (w_ea_w != 5'd0);

  // Victim: lowest-index invalid entry, else the oldest.
  always_comb begin
    w_vict       = '0;
    w_vict_found = 1'b0;
    for (int i = 0; i < NumEntries; i++) begin
      if (!r_valid[i] && !w_vict_found) begin
        w_vict       = AgeW'(i);
        w_vict_found = 1'b1;
      end
    end
    if (!w_vict_found) begin
      for (int i = 0; i < NumEntries; i++) begin
        if (r_age[i] == AgeW'(NumEntries - 1)) w_vict = AgeW'(i);
      end
    end
  end

  // Miss FSM. The IDLE miss cycle is the first stall cycle, so FILL holds
  // for FillLatency-1 further cycles; with FillLatency=1 the fill happens
  // straight out of IDLE.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_fill_now   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (stall_o) begin
          if (FillLatency == 1) begin
            w_fill_now = 1'b1;
          end else begin
            w_state_next = S_FILL;
            w_cnt_next   = c_cnt_load;
          end
        end
      end
      S_FILL: begin
        if (!stall_o) begin
          // Inputs dropped the request; abandon the fill.
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == 2'd0) begin
          w_fill_now   = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 2'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // LRU: fill edge touches the victim only; otherwise, when not stalled,
  // port A then port B so B ends as MRU. Repeating a touch is idempotent.
  always_comb begin
    w_age_next = r_age;
    if (w_fill_now) begin
      w_age_next = touch(r_age, w_vict);
    end else if (!stall_o) begin
      if (rreq_a_i && w_hit_a) w_age_next = touch(w_age_next, w_idx_a);
      if (rreq_b_i && w_hit_b) w_age_next = touch(w_age_next, w_idx_b);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      for (int i = 0; i < NumEntries; i++) begin
        r_age[i]  <= AgeW'(i);
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_age   <= w_age_next;
      if (w_we) r_rf[w_ea_w] <= wdata_a_i;
      if (w_we && w_hit_w) r_data[w_idx_w] <= wdata_a_i;
      // Fill last so it overrides a write-hit to the evicted entry; a
      // concurrent write to the filled register wins over the stale RF value.
      if (w_fill_now) begin
        r_valid[w_vict] <= 1'b1;
        r_tag[w_vict]   <= w_fill_addr;
        r_data[w_vict]  <= (w_we && w_ea_w == w_fill_addr) ? wdata_a_i : r_rf[w_fill_addr];
      end
    end
  end

`ifdef RF_CACHE_PERF_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  logic [1:0]  w_hit_inc;
  logic [32:0] w_hit_sum;

  // Hits count in unstalled cycles and in the cycle that ends a fill.
  assign w_hit_inc = (!stall_o || w_fill_now) ?
                     (2'(rreq_a_i && w_hit_a) + 2'(rreq_b_i && w_hit_b)) : 2'd0;
  assign w_hit_sum = {1'b0, r_hit_cnt} + 33'(w_hit_inc);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_hit_cnt <= w_hit_sum[32] ? 32'hFFFF_FFFF : w_hit_sum[31:0];
      if (w_fill_now && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count_o  = r_hit_cnt;
  assign miss_count_o = r_miss_cnt;
`else
  assign hit_count_o  = 32'd0;
  assign miss_count_o = 32'd0;
`endif

endmodule
`default_nettype wire
